// File: rtl/mem_req_arbiter.sv
// Multi-client memory request arbiter: picks one client, issues a single bus-master
// request, waits for completion or timeout, and returns the response to that client.
module mem_req_arbiter #(
   parameter int N_CLI       = 3,
   parameter int HIPRI_EN    = 1,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_CLI-1:0]     cli_req,
   input  logic [N_CLI-1:0]     cli_wr,
   input  logic [32*N_CLI-1:0]  cli_addr,
   input  logic [32*N_CLI-1:0]  cli_wdata,
   input  logic [4*N_CLI-1:0]   cli_wstrb,
   output logic [31:0]          cli_rdata,
   output logic [N_CLI-1:0]     cli_ready,
   output logic [N_CLI-1:0]     cli_error,
   output logic [31:0]          m_addr,
   output logic [31:0]          m_wdata,
   output logic [3:0]           m_wstrb,
   output logic                 m_wr,
   output logic                 m_req,
   input  logic [31:0]          m_rdata,
   input  logic                 m_ready,
   input  logic                 m_error,
   output logic                 busy,
   output logic [2:0]           grant_id
);

   localparam int            CW       = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
   localparam logic [CW-1:0] TO_LAST  = CW'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);
   localparam logic [2:0]    LAST_RST = 3'(N_CLI - 1);

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_DRAIN} state_t;

   state_t           r_state, w_next;
   logic [2:0]       r_grant, r_last, w_win;
   logic             r_hp, w_hp;
   logic [31:0]      r_addr, r_wdata, r_rdata, w_addr, w_wdata;
   logic [3:0]       r_wstrb, w_wstrb;
   logic             r_wr, w_wr, r_err, r_to, w_to;
   logic [CW-1:0]    r_cnt;
   logic [N_CLI-1:0] w_onehot;

   // Round-robin search upward from r_last; larger offsets are overwritten by nearer ones.
   always_comb begin
      w_win = r_last;
      w_hp  = 1'b0;
      for (int off = N_CLI; off >= 1; off--) begin
         for (int j = 0; j < N_CLI; j++) begin
            if (cli_req[j] && (j == (int'(r_last) + off) % N_CLI)) w_win = 3'(j);
         end
      end
      if (HIPRI_EN != 0 && cli_req[0]) begin
         w_win = '0;
         w_hp  = 1'b1;
      end
   end

   always_comb begin
      w_addr  = '0;
      w_wdata = '0;
      w_wstrb = '0;
      w_wr    = 1'b0;
      for (int j = 0; j < N_CLI; j++) begin
         if (w_win == 3'(j)) begin
            w_addr  = cli_addr[32*j +: 32];
            w_wdata = cli_wdata[32*j +: 32];
            w_wstrb = cli_wstrb[4*j +: 4];
            w_wr    = cli_wr[j];
         end
      end
   end

   always_comb begin
      w_onehot = '0;
      for (int j = 0; j < N_CLI; j++) w_onehot[j] = (r_grant == 3'(j));
   end

   assign w_to = (TIMEOUT_CYC != 0) && (r_cnt == TO_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (|cli_req) w_next = S_ISSUE;
         S_ISSUE: w_next = S_WAIT;
         S_WAIT:  if (m_ready || w_to) w_next = S_RESP;
         S_RESP:  w_next = (r_to && !m_ready) ? S_DRAIN : S_IDLE;
         S_DRAIN: if (m_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // A priority grant to client 0 leaves the pointer alone so clients 1..N-1 keep rotating.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_grant <= '0;
         r_last  <= LAST_RST;
         r_hp    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_wstrb <= '0;
         r_wr    <= 1'b0;
         r_rdata <= '0;
         r_err   <= 1'b0;
         r_to    <= 1'b0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (|cli_req) begin
               r_grant <= w_win;
               r_hp    <= w_hp;
               r_addr  <= w_addr;
               r_wdata <= w_wdata;
               r_wstrb <= w_wstrb;
               r_wr    <= w_wr;
            end
            S_ISSUE: r_cnt <= '0;
            S_WAIT: begin
               if (m_ready) begin
                  r_rdata <= m_rdata;
                  r_err   <= m_error;
                  r_to    <= 1'b0;
               end else if (w_to) begin
                  r_rdata <= '0;
                  r_err   <= 1'b1;
                  r_to    <= 1'b1;
               end else if (TIMEOUT_CYC != 0) begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            S_RESP: begin
               if (!r_hp) r_last <= r_grant;
               if (m_ready) r_to <= 1'b0;
            end
            S_DRAIN: if (m_ready) r_to <= 1'b0;
            default: ;
         endcase
      end
   end

   assign m_req     = (r_state == S_ISSUE);
   assign m_addr    = r_addr;
   assign m_wdata   = r_wdata;
   assign m_wstrb   = r_wstrb;
   assign m_wr      = r_wr;
   assign busy      = (r_state != S_IDLE);
   assign grant_id  = r_grant;
   assign cli_ready = (r_state == S_RESP) ? w_onehot : '0;
   assign cli_error = (r_state == S_RESP && r_err) ? w_onehot : '0;
   assign cli_rdata = (r_state == S_RESP) ? r_rdata : '0;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Scoreboard bench: stimulus pushes expected bus requests and client responses,
// a negedge monitor pops and compares them as the arbiters present them.
module tb_mem_req_arbiter;
   typedef struct {int id; logic [31:0] rdata; logic err;} rsp_t;
   typedef struct {logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb; logic wr;} mreq_t;

   logic clk = 1'b0, rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [2:0]  cli_req = '0, cli_req_b = '0, cli_wr = '0;
   logic [95:0] cli_addr = '0, cli_wdata = '0;
   logic [11:0] cli_wstrb = '0;
   logic [31:0] m_rdata = '0;
   logic        m_ready = 1'b0, m_error = 1'b0;

   logic [31:0] cli_rdata, m_addr, m_wdata, cli_rdata_b, m_addr_b, m_wdata_b;
   logic [2:0]  cli_ready, cli_error, grant_id, cli_ready_b, cli_error_b, grant_id_b;
   logic [3:0]  m_wstrb, m_wstrb_b;
   logic        m_wr, m_req, busy, m_wr_b, m_req_b, busy_b;

   mem_req_arbiter #(.N_CLI(3), .HIPRI_EN(1), .TIMEOUT_CYC(8)) dut (
      .clk(clk), .rst_n(rst_n), .cli_req(cli_req), .cli_wr(cli_wr), .cli_addr(cli_addr),
      .cli_wdata(cli_wdata), .cli_wstrb(cli_wstrb), .cli_rdata(cli_rdata), .cli_ready(cli_ready),
      .cli_error(cli_error), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wr(m_wr),
      .m_req(m_req), .m_rdata(m_rdata), .m_ready(m_ready), .m_error(m_error), .busy(busy),
      .grant_id(grant_id));

   mem_req_arbiter #(.N_CLI(3), .HIPRI_EN(0), .TIMEOUT_CYC(64)) dut_b (
      .clk(clk), .rst_n(rst_n), .cli_req(cli_req_b), .cli_wr(cli_wr), .cli_addr(cli_addr),
      .cli_wdata(cli_wdata), .cli_wstrb(cli_wstrb), .cli_rdata(cli_rdata_b), .cli_ready(cli_ready_b),
      .cli_error(cli_error_b), .m_addr(m_addr_b), .m_wdata(m_wdata_b), .m_wstrb(m_wstrb_b),
      .m_wr(m_wr_b), .m_req(m_req_b), .m_rdata(m_rdata), .m_ready(m_ready), .m_error(m_error),
      .busy(busy_b), .grant_id(grant_id_b));

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int   n_chk = 0, n_fail = 0, n_mreq = 0, last_mreq_cyc = 0, last_rdy_cyc = 0;
   logic prev_mreq = 1'b0;
   bit   sel_b = 1'b0;

   rsp_t  exp_r[$], exp_b[$];
   mreq_t exp_m[$];

   logic [31:0] addr_t [3] = '{32'h1000, 32'h2000, 32'h3000};
   logic [31:0] wdata_t[3] = '{32'hA0, 32'hA1, 32'hA2};
   logic [3:0]  wstrb_t[3] = '{4'hF, 4'hF, 4'hF};
   logic        wr_t   [3] = '{1'b0, 1'b0, 1'b0};

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, req, cyc);
      end
   endfunction

   function automatic void push_m(input int g);
      exp_m.push_back('{addr_t[g], wdata_t[g], wstrb_t[g], wr_t[g]});
   endfunction

   function automatic void check_rsp(input string p, input rsp_t e, input logic [2:0] rdy,
                                     input logic [2:0] er, input logic [31:0] rd);
      logic [2:0] oh;
      oh = 3'b001 << e.id;
      chk({p, "cli_ready"}, rdy, oh);
      chk({p, "cli_error"}, er, e.err ? oh : 3'b000);
      chk({p, "cli_rdata"}, rd, e.rdata);
   endfunction

   task automatic drive_cli();
      for (int i = 0; i < 3; i++) begin
         cli_addr[32*i +: 32]  = addr_t[i];
         cli_wdata[32*i +: 32] = wdata_t[i];
         cli_wstrb[4*i +: 4]   = wstrb_t[i];
         cli_wr[i]             = wr_t[i];
      end
   endtask

   task automatic wait_mreq();
      for (int i = 0; i < 40; i++) begin
         if (sel_b ? m_req_b : m_req) break;
         @(negedge clk);
      end
      chk("mreq_seen", sel_b ? m_req_b : m_req, 1'b1);
   endtask

   // Returns on the negedge of the response cycle.
   task automatic serve(input int dly, input logic [31:0] data, input logic err);
      wait_mreq();
      repeat (dly) @(negedge clk);
      m_rdata = data; m_error = err; m_ready = 1'b1;
      @(negedge clk);
      m_ready = 1'b0; m_rdata = '0; m_error = 1'b0;
   endtask

   // Clients held high; the one just served drops for the following IDLE cycle only.
   task automatic rr_run(input int n, input bit b);
      logic [2:0] dropped;
      for (int k = 0; k < n; k++) begin
         serve(1, 32'h100 + k, 1'b0);
         dropped = b ? cli_ready_b : cli_ready;
         if (k == n - 1) begin
            if (b) cli_req_b = '0; else cli_req = '0;
         end else begin
            if (b) cli_req_b &= ~dropped; else cli_req &= ~dropped;
            @(negedge clk); @(negedge clk);
            if (b) cli_req_b |= dropped; else cli_req |= dropped;
         end
      end
   endtask

   initial begin : monitor
      rsp_t  e;
      mreq_t m;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (m_req) begin
               n_mreq++;
               last_mreq_cyc = cyc;
               chk("mreq_back_to_back", prev_mreq, 1'b0);
               chk("mreq_expected", exp_m.size() != 0, 1'b1);
               if (exp_m.size() != 0) begin
                  m = exp_m.pop_front();
                  chk("m_addr", m_addr, m.addr);
                  chk("m_wdata", m_wdata, m.wdata);
                  chk("m_wstrb", m_wstrb, m.wstrb);
                  chk("m_wr", m_wr, m.wr);
               end
            end
            prev_mreq = m_req;
            if (cli_ready != '0) begin
               last_rdy_cyc = cyc;
               chk("ready_onehot", $onehot(cli_ready), 1'b1);
               chk("rsp_expected", exp_r.size() != 0, 1'b1);
               if (exp_r.size() != 0) begin
                  e = exp_r.pop_front();
                  check_rsp("a_", e, cli_ready, cli_error, cli_rdata);
               end
            end
            if (cli_ready_b != '0) begin
               chk("b_rsp_expected", exp_b.size() != 0, 1'b1);
               if (exp_b.size() != 0) begin
                  e = exp_b.pop_front();
                  check_rsp("b_", e, cli_ready_b, cli_error_b, cli_rdata_b);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, n_chk=%0d", n_chk);
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int c0, d, n0;
      int ids_a[6] = '{0, 1, 0, 2, 0, 1};
      int ids_b[4] = '{0, 1, 2, 0};
      drive_cli();
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 1'b0);
      chk("rst_grant_id", grant_id, 3'd0);
      chk("rst_cli_ready", cli_ready, 3'b000);
      chk("rst_m_req", m_req, 1'b0);
      chk("rst_m_addr", m_addr, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_busy", busy, 1'b0);

      // Single read, bus completes 3 cycles after m_req
      cli_req = 3'b001; c0 = cyc;
      push_m(0); exp_r.push_back('{0, 32'hDEADBEEF, 1'b0});
      serve(3, 32'hDEADBEEF, 1'b0);
      cli_req = '0;
      @(negedge clk);
      chk("rd_req_latency", last_mreq_cyc - c0, 1);
      chk("rd_rsp_latency", last_rdy_cyc - last_mreq_cyc, 4);

      // Write from client 2 completing with a bus error
      wr_t[2] = 1'b1; wstrb_t[2] = 4'h3; wdata_t[2] = 32'h0000ABCD; drive_cli();
      cli_req = 3'b100;
      push_m(2); exp_r.push_back('{2, 32'h0, 1'b1});
      serve(2, 32'h0, 1'b1);
      cli_req = '0;
      wr_t[2] = 1'b0; wstrb_t[2] = 4'hF; wdata_t[2] = 32'hA2; drive_cli();
      @(negedge clk);

      // Minimum round trip
      cli_req = 3'b001; c0 = cyc;
      push_m(0); exp_r.push_back('{0, 32'h42, 1'b0});
      serve(1, 32'h42, 1'b0);
      cli_req = '0;
      @(negedge clk);
      chk("min_round_trip", last_rdy_cyc - c0, 3);

      // Priority plus round-robin with client 0 high priority
      for (int k = 0; k < 6; k++) begin
         push_m(ids_a[k]);
         exp_r.push_back('{ids_a[k], 32'h100 + k, 1'b0});
      end
      cli_req = 3'b111;
      rr_run(6, 1'b0);
      @(negedge clk);

      // Back-to-back re-request by client 1
      cli_req = 3'b010;
      push_m(1); push_m(1);
      exp_r.push_back('{1, 32'h21, 1'b0}); exp_r.push_back('{1, 32'h22, 1'b0});
      serve(1, 32'h21, 1'b0);
      cli_req[1] = 1'b0;
      @(negedge clk);
      cli_req[1] = 1'b1; c0 = cyc;
      serve(1, 32'h22, 1'b0);
      cli_req = '0;
      @(negedge clk);
      chk("b2b_req_latency", last_mreq_cyc - c0, 1);

      // Timeout, drain blocks pending client 1 until the late completion
      cli_req = 3'b001;
      push_m(0); exp_r.push_back('{0, 32'h0, 1'b1});
      wait_mreq();
      cli_req[1] = 1'b1; push_m(1);
      for (int i = 0; i < 20 && cli_ready == '0; i++) @(negedge clk);
      chk("to_rdy_seen", |cli_ready, 1'b1);
      cli_req[0] = 1'b0;
      @(negedge clk);
      chk("to_latency", last_rdy_cyc - last_mreq_cyc, 9);
      n0 = n_mreq;
      repeat (5) @(negedge clk);
      chk("drain_no_mreq", n_mreq - n0, 0);
      chk("drain_busy", busy, 1'b1);
      m_rdata = 32'h5555; m_ready = 1'b1; d = cyc;
      @(negedge clk);
      m_ready = 1'b0; m_rdata = '0;
      exp_r.push_back('{1, 32'h1111, 1'b0});
      serve(1, 32'h1111, 1'b0);
      cli_req = '0;
      @(negedge clk);
      chk("drain_exit_latency", last_mreq_cyc - d, 2);

      // Reset during WAIT, then a stray completion
      cli_req = 3'b100; push_m(2);
      wait_mreq();
      @(negedge clk); @(negedge clk);
      rst_n = 1'b0; cli_req = '0;
      #1;
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_grant_id", grant_id, 3'd0);
      chk("midrst_cli_ready", cli_ready, 3'b000);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      m_ready = 1'b1; m_rdata = 32'h9999;
      @(negedge clk);
      m_ready = 1'b0; m_rdata = '0;
      repeat (3) @(negedge clk);
      chk("stray_busy", busy, 1'b0);
      chk("stray_grant_id", grant_id, 3'd0);
      cli_req = 3'b110;
      push_m(1); exp_r.push_back('{1, 32'h77, 1'b0});
      serve(2, 32'h77, 1'b0);
      cli_req = '0;
      @(negedge clk);

      // Plain round-robin arbiter
      sel_b = 1'b1;
      for (int k = 0; k < 4; k++) exp_b.push_back('{ids_b[k], 32'h100 + k, 1'b0});
      cli_req_b = 3'b111;
      rr_run(4, 1'b1);
      sel_b = 1'b0;
      @(negedge clk);
      chk("a_ignores_mready_idle", busy, 1'b0);

      repeat (5) @(negedge clk);
      chk("exp_m_drained", exp_m.size(), 0);
      chk("exp_r_drained", exp_r.size(), 0);
      chk("exp_b_drained", exp_b.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
